// File: rtl/mic_volume_meter_pkg.sv
// Shared definitions for the mic volume meter slice.
//   MIC_W / MAG_W / LEVEL_W : sample, magnitude and level widths
//   MID_DEFAULT / HYST_DEFAULT : mic DC midpoint and zero-cross hysteresis
//   cross_state_t : hysteresis state of the zero-crossing detector
package mic_volume_meter_pkg;

    localparam int MIC_W        = 12;
    localparam int MAG_W        = 11;
    localparam int LEVEL_W      = 4;
    localparam int MID_DEFAULT  = 2048;
    localparam int HYST_DEFAULT = 64;

    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } cross_state_t;

endpackage

// File: rtl/mic_zero_cross.sv
// Hysteresis zero-crossing detector with a saturating rising-crossing counter.
//   clk, rst         : clock, async active-low reset
//   sample_valid     : sample strobe qualifying mic_in
//   mic_in           : unsigned mic sample
//   win_clr          : clears the counter at the window-closing strobe
//   cross_cnt_next   : crossing count including the current sample
module mic_zero_cross
    import mic_volume_meter_pkg::*;
#(
    parameter int MID  = MID_DEFAULT,
    parameter int HYST = HYST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [MIC_W-1:0] mic_in,
    input  logic             win_clr,
    output logic [MIC_W-1:0] cross_cnt_next
);

    // One extra bit so MID+HYST cannot wrap.
    localparam logic [MIC_W:0] HI_TH = (MIC_W+1)'(MID + HYST);
    localparam logic [MIC_W:0] LO_TH = (MIC_W+1)'(MID - HYST);

    cross_state_t     state, state_next;
    logic [MIC_W-1:0] cross_cnt;
    logic             rising;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BELOW;
            cross_cnt <= '0;
        end else begin
            state     <= state_next;
            cross_cnt <= win_clr ? '0 : cross_cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        rising     = 1'b0;
        if (sample_valid) begin
            unique case (state)
                BELOW: if ({1'b0, mic_in} > HI_TH) begin
                    state_next = ABOVE;
                    rising     = 1'b1;
                end
                ABOVE: if ({1'b0, mic_in} < LO_TH) begin
                    state_next = BELOW;
                end
                default: state_next = BELOW;
            endcase
        end
        cross_cnt_next = (rising && (cross_cnt != '1)) ? cross_cnt + 1'b1 : cross_cnt;
    end

endmodule

// File: rtl/mic_volume_meter.sv
// Windowed peak / volume level / peak-hold / zero-crossing frequency meter.
//   clk, rst          : system clock, async active-low reset
//   sample_valid      : one-cycle strobe, mic_in valid
//   mic_in            : unsigned 12-bit mic sample
//   peak_raw          : max |mic_in-MID| of the last completed window
//   volume_level      : peak_raw[10:7]
//   volume_level_peak : peak-hold level, decays one step per DECAY_WINDOWS
//   freq              : crossings * FREQ_SCALE, saturated at 4095
//   level_valid       : one-cycle pulse when the outputs update
module mic_volume_meter
    import mic_volume_meter_pkg::*;
#(
    parameter int WINDOW        = 2000,
    parameter int MID           = MID_DEFAULT,
    parameter int HYST          = HYST_DEFAULT,
    parameter int DECAY_WINDOWS = 3,
    parameter int FREQ_SCALE    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [MIC_W-1:0]   mic_in,
    output logic [MIC_W-1:0]   peak_raw,
    output logic [LEVEL_W-1:0] volume_level,
    output logic [LEVEL_W-1:0] volume_level_peak,
    output logic [MIC_W-1:0]   freq,
    output logic               level_valid
);

    localparam int               CNT_W = $clog2(WINDOW + 1);
    localparam int               DC_W  = $clog2(DECAY_WINDOWS + 1);
    localparam logic [MIC_W-1:0] MID_V = MIC_W'(MID);

    logic [CNT_W-1:0]   sample_cnt;
    logic [MAG_W-1:0]   running_peak;
    logic [DC_W-1:0]    decay_cnt;

    logic [MIC_W-1:0]   diff;
    logic [MAG_W-1:0]   mag;
    logic [MAG_W-1:0]   peak_next;
    logic [LEVEL_W-1:0] new_level;
    logic [MIC_W-1:0]   cross_next;
    logic [31:0]        freq_prod;
    logic [MIC_W-1:0]   freq_sat;
    logic               win_end;

    always_comb begin
        diff      = (mic_in >= MID_V) ? (mic_in - MID_V) : (MID_V - mic_in);
        // Only MID-0 can exceed the 11-bit range.
        mag       = diff[MIC_W-1] ? '1 : diff[MAG_W-1:0];
        peak_next = (mag > running_peak) ? mag : running_peak;
        new_level = peak_next[MAG_W-1 -: LEVEL_W];
        win_end   = sample_valid && (sample_cnt == CNT_W'(WINDOW - 1));
        freq_prod = 32'(cross_next) * 32'(FREQ_SCALE);
        freq_sat  = (freq_prod > 32'd4095) ? '1 : freq_prod[MIC_W-1:0];
    end

    mic_zero_cross #(
        .MID  (MID),
        .HYST (HYST)
    ) u_zero_cross (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .mic_in         (mic_in),
        .win_clr        (win_end),
        .cross_cnt_next (cross_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt        <= '0;
            running_peak      <= '0;
            decay_cnt         <= '0;
            peak_raw          <= '0;
            volume_level      <= '0;
            volume_level_peak <= '0;
            freq              <= '0;
            level_valid       <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (win_end) begin
                sample_cnt   <= '0;
                running_peak <= '0;
                peak_raw     <= {1'b0, peak_next};
                volume_level <= new_level;
                freq         <= freq_sat;
                level_valid  <= 1'b1;
                if (new_level >= volume_level_peak) begin
                    volume_level_peak <= new_level;
                    decay_cnt         <= '0;
                end else if (decay_cnt == DC_W'(DECAY_WINDOWS - 1)) begin
                    if (volume_level_peak != '0)
                        volume_level_peak <= volume_level_peak - 1'b1;
                    decay_cnt <= '0;
                end else begin
                    decay_cnt <= decay_cnt + 1'b1;
                end
            end else if (sample_valid) begin
                sample_cnt   <= sample_cnt + 1'b1;
                running_peak <= peak_next;
            end
        end
    end

endmodule

// File: tb/tb_mic_volume_meter.sv
`timescale 1ns/1ps
module tb_mic_volume_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = 12'd0;
    logic [11:0] peak_raw, freq;
    logic [3:0]  volume_level, volume_level_peak;
    logic        level_valid;

    // Small-window instance used for the long decay-to-floor run.
    logic        sv2 = 1'b0;
    logic [11:0] mic2 = 12'd0;
    logic [11:0] s_peak_raw, s_freq;
    logic [3:0]  s_volume_level, s_volume_level_peak;
    logic        s_level_valid;

    int passed = 0;
    int total  = 0;
    int lv_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (level_valid) lv_count++;

    mic_volume_meter dut (
        .clk               (clk),
        .rst               (rst),
        .sample_valid      (sample_valid),
        .mic_in            (mic_in),
        .peak_raw          (peak_raw),
        .volume_level      (volume_level),
        .volume_level_peak (volume_level_peak),
        .freq              (freq),
        .level_valid       (level_valid)
    );

    mic_volume_meter #(
        .WINDOW (16)
    ) dut_small (
        .clk               (clk),
        .rst               (rst),
        .sample_valid      (sv2),
        .mic_in            (mic2),
        .peak_raw          (s_peak_raw),
        .volume_level      (s_volume_level),
        .volume_level_peak (s_volume_level_peak),
        .freq              (s_freq),
        .level_valid       (s_level_valid)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_n(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            mic_in = v;
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (peak_raw !== 12'd0) $display("FAIL rst_peak_raw: got %0d expected 0", peak_raw); else passed++;
        total++; if (level_valid !== 1'b0) $display("FAIL rst_level_valid: got %0d expected 0", level_valid); else passed++;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (peak_raw !== 12'd0) $display("FAIL idle_peak_raw: got %0d expected 0", peak_raw); else passed++;
        total++; if (volume_level !== 4'd0) $display("FAIL idle_volume_level: got %0d expected 0", volume_level); else passed++;
        total++; if (volume_level_peak !== 4'd0) $display("FAIL idle_volume_level_peak: got %0d expected 0", volume_level_peak); else passed++;
        total++; if (freq !== 12'd0) $display("FAIL idle_freq: got %0d expected 0", freq); else passed++;
        total++; if (lv_count !== 0) $display("FAIL idle_level_valid_count: got %0d expected 0", lv_count); else passed++;
    endtask

    task automatic test_silence();
        int base;
        base = lv_count;
        send_n(12'd2048, 1999);
        total++; if (level_valid !== 1'b0 || lv_count !== base)
            $display("FAIL silence_early_valid: got lv=%0d count=%0d expected 0/%0d", level_valid, lv_count, base); else passed++;
        send_n(12'd2048, 1);
        total++; if (level_valid !== 1'b1) $display("FAIL silence_level_valid: got %0d expected 1", level_valid); else passed++;
        total++; if (peak_raw !== 12'd0) $display("FAIL silence_peak_raw: got %0d expected 0", peak_raw); else passed++;
        total++; if (volume_level !== 4'd0) $display("FAIL silence_volume_level: got %0d expected 0", volume_level); else passed++;
        total++; if (freq !== 12'd0) $display("FAIL silence_freq: got %0d expected 0", freq); else passed++;
        @(negedge clk);
        total++; if (level_valid !== 1'b0) $display("FAIL silence_pulse_width: got %0d expected 0", level_valid); else passed++;
        total++; if (lv_count - base !== 1) $display("FAIL silence_pulse_count: got %0d expected 1", lv_count - base); else passed++;
    endtask

    task automatic test_single_peak();
        send_n(12'd3000, 1);
        send_n(12'd2048, 1999);
        total++; if (level_valid !== 1'b1) $display("FAIL single_level_valid: got %0d expected 1", level_valid); else passed++;
        total++; if (peak_raw !== 12'd952) $display("FAIL single_peak_raw: got %0d expected 952", peak_raw); else passed++;
        total++; if (volume_level !== 4'd7) $display("FAIL single_volume_level: got %0d expected 7", volume_level); else passed++;
        total++; if (volume_level_peak !== 4'd7) $display("FAIL single_volume_level_peak: got %0d expected 7", volume_level_peak); else passed++;
        total++; if (freq !== 12'd10) $display("FAIL single_freq: got %0d expected 10", freq); else passed++;
        @(negedge clk);
        total++; if (peak_raw !== 12'd952) $display("FAIL single_hold_peak_raw: got %0d expected 952", peak_raw); else passed++;
    endtask

    task automatic test_square();
        for (int p = 0; p < 50; p++) begin
            send_n(12'd1548, 20);
            send_n(12'd2548, 20);
        end
        total++; if (level_valid !== 1'b1) $display("FAIL square_level_valid: got %0d expected 1", level_valid); else passed++;
        total++; if (freq !== 12'd500) $display("FAIL square_freq: got %0d expected 500", freq); else passed++;
        total++; if (peak_raw !== 12'd500) $display("FAIL square_peak_raw: got %0d expected 500", peak_raw); else passed++;
        total++; if (volume_level !== 4'd3) $display("FAIL square_volume_level: got %0d expected 3", volume_level); else passed++;
        total++; if (volume_level_peak !== 4'd7) $display("FAIL square_volume_level_peak: got %0d expected 7", volume_level_peak); else passed++;
    endtask

    task automatic test_decay();
        logic [3:0] exp_pk [6];
        exp_pk = '{4'd15, 4'd15, 4'd14, 4'd14, 4'd14, 4'd13};
        send_n(12'd0, 2000);
        total++; if (peak_raw !== 12'd2047) $display("FAIL decay_sat_peak_raw: got %0d expected 2047", peak_raw); else passed++;
        total++; if (volume_level !== 4'd15) $display("FAIL decay_volume_level: got %0d expected 15", volume_level); else passed++;
        total++; if (volume_level_peak !== 4'd15) $display("FAIL decay_w1_peak: got %0d expected 15", volume_level_peak); else passed++;
        total++; if (freq !== 12'd0) $display("FAIL decay_w1_freq: got %0d expected 0", freq); else passed++;
        for (int w = 0; w < 6; w++) begin
            send_n(12'd2048, 2000);
            total++; if (volume_level_peak !== exp_pk[w])
                $display("FAIL decay_w%0d_peak: got %0d expected %0d", w + 2, volume_level_peak, exp_pk[w]); else passed++;
        end
        total++; if (volume_level !== 4'd0) $display("FAIL decay_w7_volume_level: got %0d expected 0", volume_level); else passed++;
    endtask

    task automatic test_back_to_back_freq_sat();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            mic_in = (i % 2 == 0) ? 12'd2548 : 12'd1548;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        total++; if (level_valid !== 1'b1) $display("FAIL b2b_level_valid: got %0d expected 1", level_valid); else passed++;
        total++; if (freq !== 12'd4095) $display("FAIL b2b_freq_sat: got %0d expected 4095", freq); else passed++;
        total++; if (peak_raw !== 12'd500) $display("FAIL b2b_peak_raw: got %0d expected 500", peak_raw); else passed++;
        total++; if (volume_level_peak !== 4'd13) $display("FAIL b2b_volume_level_peak: got %0d expected 13", volume_level_peak); else passed++;
    endtask

    task automatic test_reset_mid_window();
        int base;
        send_n(12'd4095, 1000);
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b1;
        mic_in = 12'd4095;
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        total++; if (peak_raw !== 12'd0 || freq !== 12'd0)
            $display("FAIL midrst_cleared: got peak=%0d freq=%0d expected 0/0", peak_raw, freq); else passed++;
        base = lv_count;
        send_n(12'd2048, 1999);
        total++; if (lv_count !== base || level_valid !== 1'b0)
            $display("FAIL midrst_early_valid: got count=%0d lv=%0d expected %0d/0", lv_count, level_valid, base); else passed++;
        send_n(12'd2048, 1);
        total++; if (level_valid !== 1'b1) $display("FAIL midrst_level_valid: got %0d expected 1", level_valid); else passed++;
        total++; if (peak_raw !== 12'd0) $display("FAIL midrst_peak_raw: got %0d expected 0", peak_raw); else passed++;
        total++; if (volume_level_peak !== 4'd0) $display("FAIL midrst_volume_level_peak: got %0d expected 0", volume_level_peak); else passed++;
    endtask

    task automatic test_decay_floor();
        int exp_pk;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); sv2 = 1'b1; mic2 = 12'd0;
        end
        @(negedge clk); sv2 = 1'b0;
        total++; if (s_volume_level_peak !== 4'd15) $display("FAIL floor_w0_peak: got %0d expected 15", s_volume_level_peak); else passed++;
        for (int k = 1; k <= 50; k++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk); sv2 = 1'b1; mic2 = 12'd2048;
            end
            @(negedge clk); sv2 = 1'b0;
            exp_pk = (k / 3 >= 15) ? 0 : 15 - k / 3;
            total++; if (s_level_valid !== 1'b1 || s_volume_level_peak !== 4'(exp_pk))
                $display("FAIL floor_w%0d: got lv=%0d peak=%0d expected 1/%0d", k, s_level_valid, s_volume_level_peak, exp_pk); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_silence();
        test_single_peak();
        test_square();
        test_decay();
        test_back_to_back_freq_sat();
        test_reset_mid_window();
        test_decay_floor();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mic_volume_meter.md
Name: mic_volume_meter

Overview:
- Stage directly downstream of the microphone capture block and upstream of the LED bar, seven-segment and game consumers.
- Operates on the 12-bit mic samples in the system clock domain, qualified by a sample strobe.
- Each window produces a windowed peak magnitude, a 0-15 volume level, a decaying peak-hold level, and a zero-crossing frequency estimate.
- Replaces the separate slow-clock volume and frequency logic with one single-clock block.

Parameters:
- WINDOW, 2000: samples per measurement window (0.1 s at 20 kHz).
- MID, 2048: mic DC midpoint subtracted from each sample.
- HYST, 64: zero-crossing hysteresis band, ± around MID.
- DECAY_WINDOWS, 3: windows between one-step decrements of the peak-hold level.
- FREQ_SCALE, 10: Hz per crossing per window (sample rate / WINDOW).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-low reset; rst=0 clears all state immediately.
- sample_valid  in  1  one-cycle strobe; mic_in is valid on this cycle.
- mic_in  in  12  unsigned mic sample.
- peak_raw  out  12  max |mic_in-MID| of the last completed window.
- volume_level  out  4  peak_raw quantised to 0..15.
- volume_level_peak  out  4  peak-hold level with decay.
- freq  out  12  estimated frequency in Hz, saturated at 4095.
- level_valid  out  1  one-cycle pulse when all outputs update.

Behaviour:
- Reset (async, rst low): all outputs 0; sample counter 0; running peak 0; crossing count 0; crossing state BELOW; decay counter 0.
- Per accepted sample (sample_valid=1):
  - mag = mic_in>=MID ? mic_in-MID : MID-mic_in, saturated to 2047 (11 bits).
  - running_peak = max(running_peak, mag).
  - sample_cnt increments.
- Crossing FSM, two states, sampled only on sample_valid:
  - BELOW -> ABOVE when mic_in > MID+HYST; crossing_cnt increments, saturating at 4095.
  - ABOVE -> BELOW when mic_in < MID-HYST.
  - Otherwise the state holds. Samples inside the band never toggle the state.
- Window end is the sample that brings sample_cnt to WINDOW. On the next clk edge:
  - peak_raw <= max(running_peak, mag of this sample), zero-extended to 12 bits.
  - volume_level <= that value [10:7].
  - freq <= min(4095, crossings_including_this_sample * FREQ_SCALE), computed as a constant multiply with saturation.
  - Peak hold: if the new level >= volume_level_peak, load it and clear the decay counter. Otherwise increment the decay counter; when it reaches DECAY_WINDOWS, decrement volume_level_peak by 1 (floor 0) and clear the counter.
  - running_peak, crossing_cnt and sample_cnt clear to 0. The crossing FSM state is kept across windows.
  - level_valid pulses high for exactly that one cycle.
- Latency: outputs are visible 1 clk after the window-closing sample_valid.
- sample_valid on consecutive cycles is legal; every strobe counts.
- sample_valid while rst is low is ignored.
- Reset mid-window discards the partial window. The first level_valid after release comes after exactly WINDOW further samples.
- Outputs hold between windows. No output changes without level_valid, except on reset.

Decomposition:
- Shared package holds: MIC_W=12, MAG_W=11, LEVEL_W=4, the MID/HYST defaults, and the crossing-state enum (BELOW, ABOVE).
- One natural sub-module, mic_zero_cross: the hysteresis FSM plus the saturating crossing counter, with a window-clear input.
- The peak, quantise and decay logic stays in the top.

Test Plan:
- Reset: hold rst=0 for 5 clk, then release with no strobes -> all outputs 0 and level_valid never asserts.
- Constant mic_in=2048 for 2000 strobes -> level_valid once; peak_raw=0, volume_level=0, freq=0.
- One sample of 3000 among 1999 samples of 2048 -> peak_raw=952, volume_level=7, volume_level_peak=7, freq=10 (one rising crossing).
- Square wave alternating 2048±500, period 40 samples, 2000 strobes -> 50 crossings; freq=500, peak_raw=500, volume_level=3.
- Peak decay (DECAY_WINDOWS=3): one window at level 15, then silent windows -> volume_level_peak is 15,15,15,14 after windows 1-4, 13 after window 7, and reaches 0 later (never underflows).
- Reset mid-window: after 1000 strobes of 4095, pull rst low for one cycle, then send 2000 strobes of 2048 -> the first level_valid follows the 2000th new strobe; peak_raw=0, volume_level_peak=0.
